regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_if.sv | 47 ++++
 rtl/regfile_write_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Bundle for the register-file write arbiter: two write requesters, a reservation
// port, the registered register-file write port and the busy scoreboard.
interface regfile_write_arbiter_if #(
  parameter int unsigned DataSz = 32
);

  // Requester 0 (ALU commit)
  logic              in_req0_valid;
  logic [4:0]        in_req0_register_select;
  logic [DataSz:0]   in_req0_data;
  logic              out_req0_ready;

  // Requester 1 (load return)
  logic              in_req1_valid;
  logic [4:0]        in_req1_register_select;
  logic [DataSz:0]   in_req1_data;
  logic              out_req1_ready;

  // Destination reservation
  logic              in_reserve_valid;
  logic [4:0]        in_reserve_register_select;

  // Register-file write port and scoreboard
  logic              out_write_enable;
  logic [4:0]        out_write_register_select;
  logic [DataSz:0]   out_write_data;
  logic [31:0]       out_busy;

  // Requesters, reservation source and register-file side
  modport master (
    output in_req0_valid, in_req0_register_select, in_req0_data,
    output in_req1_valid, in_req1_register_select, in_req1_data,
    output in_reserve_valid, in_reserve_register_select,
    input  out_req0_ready, out_req1_ready,
    input  out_write_enable, out_write_register_select, out_write_data, out_busy
  );

  // The arbiter itself
  modport slave (
    input  in_req0_valid, in_req0_register_select, in_req0_data,
    input  in_req1_valid, in_req1_register_select, in_req1_data,
    input  in_reserve_valid, in_reserve_register_select,
    output out_req0_ready, out_req1_ready,
    output out_write_enable, out_write_register_select, out_write_data, out_busy
  );

endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter between two register-file writers with a registered write
// port and a pending-write scoreboard. Register 0 is hardwired: writes to it are
// accepted and dropped, and it can never be marked busy.
module regfile_write_arbiter #(
  parameter int unsigned DataSz        = 32,
  parameter int unsigned num_registers = 32
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  regfile_write_arbiter_if.slave  bus
);

  logic                     last_grant_q, last_grant_d;
  logic                     write_enable_q, write_enable_d;
  logic [4:0]               write_sel_q, write_sel_d;
  logic [DataSz:0]          write_data_q, write_data_d;
  logic [num_registers-1:0] busy_q, busy_d;

  logic                     ready0, ready1;
  logic                     accept0, accept1, accept_any;
  logic [4:0]               accept_sel;
  logic [DataSz:0]          accept_data;

  // Grant: single valid wins outright, a tie goes to whoever did not win last.
  // Readies are forced low during reset so nothing is accepted then.
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (RESET_N) begin
      if (bus.in_req0_valid && bus.in_req1_valid) begin
        ready0 = last_grant_q;
        ready1 = ~last_grant_q;
      end else begin
        ready0 = bus.in_req0_valid;
        ready1 = bus.in_req1_valid;
      end
    end
  end

  // Select the accepted request (at most one can be accepted per cycle)
  always_comb begin
    accept0     = bus.in_req0_valid & ready0;
    accept1     = bus.in_req1_valid & ready1;
    accept_any  = accept0 | accept1;
    accept_sel  = accept1 ? bus.in_req1_register_select : bus.in_req0_register_select;
    accept_data = accept1 ? bus.in_req1_data : bus.in_req0_data;
  end

  // Next-state for grant pointer, write port and scoreboard
  always_comb begin
    last_grant_d   = last_grant_q;
    write_enable_d = 1'b0;
    write_sel_d    = write_sel_q;
    write_data_d   = write_data_q;
    busy_d         = busy_q;

    if (accept0) begin
      last_grant_d = 1'b0;
    end else if (accept1) begin
      last_grant_d = 1'b1;
    end

    // Select and data only move on a real write, so they hold across idle cycles
    // and across discarded x0 writes.
    if (accept_any && (accept_sel != 5'd0)) begin
      write_enable_d      = 1'b1;
      write_sel_d         = accept_sel;
      write_data_d        = accept_data;
      busy_d[accept_sel]  = 1'b0;
    end

    // Set after clear so a same-register reserve and write leaves it busy.
    if (bus.in_reserve_valid && (bus.in_reserve_register_select != 5'd0)) begin
      busy_d[bus.in_reserve_register_select] = 1'b1;
    end

    busy_d[0] = 1'b0;
  end

  // State registers; reset leaves requester 0 favoured on the first tie
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      last_grant_q   <= 1'b1;
      write_enable_q <= 1'b0;
      write_sel_q    <= 5'd0;
      write_data_q   <= '0;
      busy_q         <= '0;
    end else begin
      last_grant_q   <= last_grant_d;
      write_enable_q <= write_enable_d;
      write_sel_q    <= write_sel_d;
      write_data_q   <= write_data_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.out_req0_ready            = ready0;
  assign bus.out_req1_ready            = ready1;
  assign bus.out_write_enable          = write_enable_q;
  assign bus.out_write_register_select = write_sel_q;
  assign bus.out_write_data            = write_data_q;
  assign bus.out_busy                  = busy_q;

endmodule
